// File: rtl/vga_display_engine.sv
// Parametrised VGA back-end: pixel-tick divider, programmable H/V timing, pixel
// request port, frame-latched test patterns and a start-of-vblank update strobe.
module vga_display_engine #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_VIS       = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_VIS       = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_POL    = 1'b0,
  parameter logic [7:0]  SOLID_COLOR = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [7:0]  pix_in,
  output logic [10:0] req_x,
  output logic [9:0]  req_y,
  output logic        req_valid,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  vga_color,
  output logic        update
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SEG_LEN = H_VIS / 8;
  localparam int unsigned SEG_W   = $clog2(SEG_LEN + 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [10:0]      h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic [1:0]       mode_q, mode_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [2:0]       bar_q, bar_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [7:0]       color_q, color_d;
  logic             update_q, update_d;
  logic             tick;
  logic             visible;
  logic [7:0]       bar_color;
  logic [7:0]       pattern;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      mode_q   <= '0;
      seg_q    <= '0;
      bar_q    <= '0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      color_q  <= '0;
      update_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      mode_q   <= mode_d;
      seg_q    <= seg_d;
      bar_q    <= bar_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      color_q  <= color_d;
      update_q <= update_d;
    end
  end

  assign visible = (h_q < 11'(H_VIS)) && (v_q < 10'(V_VIS));

  // Bar colour follows the segment counter, so no divide by H_VIS/8 is needed
  always_comb begin
    bar_color = 8'h00;
    unique case (bar_q)
      3'd0:    bar_color = 8'hFF;
      3'd1:    bar_color = 8'hFC;
      3'd2:    bar_color = 8'h1F;
      3'd3:    bar_color = 8'h1C;
      3'd4:    bar_color = 8'hE3;
      3'd5:    bar_color = 8'hE0;
      3'd6:    bar_color = 8'h03;
      default: bar_color = 8'h00;
    endcase
  end

  always_comb begin
    pattern = 8'h00;
    unique case (mode_q)
      2'd0:    pattern = SOLID_COLOR;
      2'd1:    pattern = bar_color;
      2'd2:    pattern = (h_q[5] ^ v_q[5]) ? 8'hFF : 8'h00;
      default: pattern = pix_in;
    endcase
  end

  // Next state: everything except the divider and strobe advances on tick only
  always_comb begin
    div_d    = div_q;
    h_d      = h_q;
    v_d      = v_q;
    mode_d   = mode_q;
    seg_d    = seg_q;
    bar_d    = bar_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    color_d  = color_q;
    update_d = 1'b0;
    tick     = (div_q == DIV_W'(CLK_DIV - 1));

    if (!tick) begin
      div_d = div_q + DIV_W'(1);
    end else begin
      div_d   = '0;
      hsync_d = ((h_q >= 11'(H_VIS + H_FP)) && (h_q < 11'(H_VIS + H_FP + H_SYNC)))
                ? SYNC_POL : ~SYNC_POL;
      vsync_d = ((v_q >= 10'(V_VIS + V_FP)) && (v_q < 10'(V_VIS + V_FP + V_SYNC)))
                ? SYNC_POL : ~SYNC_POL;
      color_d = visible ? pattern : 8'h00;

      if (h_q == 11'(H_TOTAL - 1)) begin
        h_d   = '0;
        seg_d = '0;
        bar_d = '0;
        if (v_q == 10'(V_VIS - 1)) begin
          update_d = 1'b1;
        end
        if (v_q == 10'(V_TOTAL - 1)) begin
          v_d    = '0;
          mode_d = mode;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 11'd1;
        if (seg_q == SEG_W'(SEG_LEN - 1)) begin
          seg_d = '0;
          bar_d = bar_q + 3'd1;
        end else begin
          seg_d = seg_q + SEG_W'(1);
        end
      end
    end
  end

  assign req_x     = h_q;
  assign req_y     = v_q;
  assign req_valid = visible;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign vga_color = color_q;
  assign update    = update_q;

endmodule

// File: tb/tb_vga_display_engine.sv
// Bench for vga_display_engine: default-timing instance, a scaled-down instance
// checked pixel by pixel against a scoreboard model, and a CLK_DIV=1 instance.
module tb_vga_display_engine;

  localparam int SM_DIV   = 2;
  localparam int SH_VIS   = 64;
  localparam int SH_FP    = 4;
  localparam int SH_SYNC  = 6;
  localparam int SH_BP    = 6;
  localparam int SV_VIS   = 40;
  localparam int SV_FP    = 2;
  localparam int SV_SYNC  = 2;
  localparam int SV_BP    = 2;
  localparam int SH_TOT   = SH_VIS + SH_FP + SH_SYNC + SH_BP;
  localparam int SV_TOT   = SV_VIS + SV_FP + SV_SYNC + SV_BP;
  localparam int SM_FRAME = SH_TOT * SV_TOT * SM_DIV;
  localparam logic [7:0] BARS [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Default-parameter instance
  logic        rst_def;
  logic [1:0]  mode_def;
  logic [7:0]  pix_def;
  logic [10:0] req_x_def;
  logic [9:0]  req_y_def;
  logic        req_valid_def, hsync_def, vsync_def, update_def;
  logic [7:0]  vga_color_def;

  vga_display_engine u_def (
    .clk(clk), .rst(rst_def), .mode(mode_def), .pix_in(pix_def),
    .req_x(req_x_def), .req_y(req_y_def), .req_valid(req_valid_def),
    .hsync(hsync_def), .vsync(vsync_def), .vga_color(vga_color_def), .update(update_def)
  );

  // Scaled-down instance under scoreboard
  logic        rst_sm;
  logic [1:0]  mode_sm;
  logic [7:0]  pix_sm;
  logic [10:0] req_x_sm;
  logic [9:0]  req_y_sm;
  logic        req_valid_sm, hsync_sm, vsync_sm, update_sm;
  logic [7:0]  vga_color_sm;

  vga_display_engine #(
    .CLK_DIV(SM_DIV), .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
  ) u_sm (
    .clk(clk), .rst(rst_sm), .mode(mode_sm), .pix_in(pix_sm),
    .req_x(req_x_sm), .req_y(req_y_sm), .req_valid(req_valid_sm),
    .hsync(hsync_sm), .vsync(vsync_sm), .vga_color(vga_color_sm), .update(update_sm)
  );

  assign pix_sm = req_x_sm[7:0];

  // Single-clock-per-pixel instance with active-high sync
  logic        rst_t1;
  logic [1:0]  mode_t1;
  logic [7:0]  pix_t1;
  logic [10:0] req_x_t1;
  logic [9:0]  req_y_t1;
  logic        req_valid_t1, hsync_t1, vsync_t1, update_t1;
  logic [7:0]  vga_color_t1;

  vga_display_engine #(
    .CLK_DIV(1), .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
  ) u_t1 (
    .clk(clk), .rst(rst_t1), .mode(mode_t1), .pix_in(pix_t1),
    .req_x(req_x_t1), .req_y(req_y_t1), .req_valid(req_valid_t1),
    .hsync(hsync_t1), .vsync(vsync_t1), .vga_color(vga_color_t1), .update(update_t1)
  );

  assign pix_t1 = req_x_t1[7:0];

  // Model state of u_sm after the most recent clock edge
  int         m_div, m_h, m_v;
  logic [1:0] m_mode;
  logic       m_upd;
  int         upd_seen;
  logic [9:0] sb_q [$];

  function automatic logic [9:0] sm_predict(int x, int y, logic [1:0] md);
    logic [7:0] c;
    logic       hs, vs;
    hs = !((x >= SH_VIS + SH_FP) && (x < SH_VIS + SH_FP + SH_SYNC));
    vs = !((y >= SV_VIS + SV_FP) && (y < SV_VIS + SV_FP + SV_SYNC));
    c  = 8'h00;
    if (x < SH_VIS && y < SV_VIS) begin
      case (md)
        2'd0:    c = 8'h03;
        2'd1:    c = BARS[x / (SH_VIS / 8)];
        2'd2:    c = ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 8'hFF : 8'h00;
        default: c = 8'(x);
      endcase
    end
    return {c, hs, vs};
  endfunction

  // One clock of u_sm: push the pixel the next edge should register, then check
  task automatic sm_step();
    logic       tick;
    logic [1:0] md;
    logic [9:0] exp_o;
    logic [9:0] got;
    tick = (m_div == SM_DIV - 1);
    md   = mode_sm;
    if (tick) sb_q.push_back(sm_predict(m_h, m_v, m_mode));
    @(negedge clk);
    m_upd = tick && (m_h == SH_TOT - 1) && (m_v == SV_VIS - 1);
    if (tick) begin
      m_div = 0;
      if (m_h == SH_TOT - 1) begin
        m_h = 0;
        if (m_v == SV_TOT - 1) begin
          m_v    = 0;
          m_mode = md;
        end else begin
          m_v++;
        end
      end else begin
        m_h++;
      end
    end else begin
      m_div++;
    end
    checks++;
    if (req_x_sm !== 11'(m_h) || req_y_sm !== 10'(m_v)) begin
      errors++;
      $display("FAIL sm_counters: got x=%0d y=%0d, want x=%0d y=%0d", req_x_sm, req_y_sm, m_h, m_v);
    end
    checks++;
    if (req_valid_sm !== ((m_h < SH_VIS) && (m_v < SV_VIS))) begin
      errors++;
      $display("FAIL sm_req_valid: got %b at x=%0d y=%0d", req_valid_sm, m_h, m_v);
    end
    checks++;
    if (update_sm !== m_upd) begin
      errors++;
      $display("FAIL sm_update: got %b, want %b at x=%0d y=%0d", update_sm, m_upd, m_h, m_v);
    end
    if (update_sm === 1'b1) upd_seen++;
    if (tick) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sm_scoreboard: no expected pixel queued");
      end else begin
        exp_o = sb_q.pop_front();
        got   = {vga_color_sm, hsync_sm, vsync_sm};
        if (got !== exp_o) begin
          errors++;
          $display("FAIL sm_pixel: got color=%h hs=%b vs=%b, want color=%h hs=%b vs=%b (next x=%0d y=%0d)",
                   got[9:2], got[1], got[0], exp_o[9:2], exp_o[1], exp_o[0], m_h, m_v);
        end
      end
    end
  endtask

  task automatic sm_run(int n);
    for (int i = 0; i < n; i++) sm_step();
  endtask

  task automatic test_reset();
    rst_sm = 1'b1; rst_t1 = 1'b1;
    @(negedge clk);
    rst_sm = 1'b0; rst_t1 = 1'b0;
    m_div = 0; m_h = 0; m_v = 0; m_mode = 2'd0; m_upd = 1'b0;
    sb_q.delete();
    checks++;
    if ({req_x_sm, req_y_sm} !== 21'd0) begin
      errors++;
      $display("FAIL reset_counters: got x=%0d y=%0d, want 0 0", req_x_sm, req_y_sm);
    end
    checks++;
    if ({vga_color_sm, hsync_sm, vsync_sm, update_sm} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got color=%h hs=%b vs=%b upd=%b, want 00 1 1 0",
               vga_color_sm, hsync_sm, vsync_sm, update_sm);
    end
    checks++;
    if ({hsync_t1, vsync_t1} !== 2'b00) begin
      errors++;
      $display("FAIL reset_sync_pol1: got hs=%b vs=%b, want 0 0", hsync_t1, vsync_t1);
    end
  endtask

  task automatic test_reset_midline();
    int n;
    rst_def = 1'b1;
    @(negedge clk);
    rst_def = 1'b0;
    n = 0;
    while (req_x_def !== 11'd400 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_x_def !== 11'd400) begin
      errors++;
      $display("FAIL midline_reach: got x=%0d, want 400", req_x_def);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (vga_color_def !== 8'h03) begin
      errors++;
      $display("FAIL midline_solid: got %h, want 03", vga_color_def);
    end
    rst_def = 1'b1;
    @(negedge clk);
    rst_def = 1'b0;
    checks++;
    if ({req_x_def, req_y_def, hsync_def, vsync_def, vga_color_def, update_def}
        !== {11'd0, 10'd0, 1'b1, 1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL midline_reset: got x=%0d y=%0d hs=%b vs=%b color=%h upd=%b, want 0 0 1 1 00 0",
               req_x_def, req_y_def, hsync_def, vsync_def, vga_color_def, update_def);
    end
    n = 0;
    while (req_x_def !== 11'd1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL midline_divider: first h step after %0d clks, want 4", n);
    end
  endtask

  task automatic test_line_timing();
    int n, w, per;
    bit vs_low;
    vs_low = 1'b0;
    rst_def = 1'b1;
    @(negedge clk);
    rst_def = 1'b0;
    n = 0;
    while (hsync_def !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
      if (vsync_def !== 1'b1) vs_low = 1'b1;
    end
    checks++;
    if (n != 2628) begin
      errors++;
      $display("FAIL hsync_first_fall: got clk %0d, want 2628", n);
    end
    w = 0;
    while (hsync_def === 1'b0 && w < 1000) begin
      w++;
      @(negedge clk);
    end
    checks++;
    if (w != 384) begin
      errors++;
      $display("FAIL hsync_width: got %0d clks, want 384", w);
    end
    per = w;
    while (hsync_def !== 1'b0 && per < 4000) begin
      @(negedge clk);
      per++;
      if (vsync_def !== 1'b1) vs_low = 1'b1;
    end
    checks++;
    if (per != 3200) begin
      errors++;
      $display("FAIL hsync_period: got %0d clks, want 3200", per);
    end
    checks++;
    if (vs_low) begin
      errors++;
      $display("FAIL vsync_line0: got vsync low on line 0, want high");
    end
  endtask

  task automatic test_solid();
    mode_sm = 2'd0;
    sm_run(SM_FRAME);
  endtask

  task automatic test_bars();
    mode_sm  = 2'd1;
    upd_seen = 0;
    sm_run(2 * SM_FRAME);
    checks++;
    if (upd_seen != 2) begin
      errors++;
      $display("FAIL update_count: got %0d pulses in 2 frames, want 2", upd_seen);
    end
  endtask

  task automatic test_checker();
    mode_sm = 2'd2;
    sm_run(2 * SM_FRAME);
  endtask

  task automatic test_mode_switch();
    mode_sm = 2'd1;
    for (int i = 0; i < 2 * SM_FRAME; i++) begin
      if (m_h == 0 && m_v == 0 && m_div == 0 && m_mode == 2'd1) break;
      sm_step();
    end
    for (int i = 0; i < SM_FRAME; i++) begin
      if (m_v == 20) break;
      sm_step();
    end
    mode_sm = 2'd3;
    sm_run(2 * SM_FRAME);
  endtask

  task automatic test_clkdiv1();
    int x, y;
    mode_t1 = 2'd0;
    rst_t1  = 1'b1;
    @(negedge clk);
    rst_t1 = 1'b0;
    for (int n = 1; n <= 28; n++) begin
      @(negedge clk);
      x = (n - 1) % 14;
      y = (n - 1) / 14;
      checks++;
      if (req_x_t1 !== 11'(n % 14) || req_y_t1 !== 10'(n / 14)) begin
        errors++;
        $display("FAIL t1_counters: got x=%0d y=%0d, want x=%0d y=%0d", req_x_t1, req_y_t1, n % 14, n / 14);
      end
      checks++;
      if (hsync_t1 !== ((x == 10) || (x == 11))) begin
        errors++;
        $display("FAIL t1_hsync: got %b for x=%0d", hsync_t1, x);
      end
      checks++;
      if (vga_color_t1 !== ((x < 8 && y < 4) ? 8'h03 : 8'h00)) begin
        errors++;
        $display("FAIL t1_color: got %h for x=%0d y=%0d", vga_color_t1, x, y);
      end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_def = 1'b1; rst_sm = 1'b1; rst_t1 = 1'b1;
    mode_def = 2'd0; mode_sm = 2'd0; mode_t1 = 2'd0;
    pix_def = 8'h00;
    test_reset();
    test_solid();
    test_bars();
    test_checker();
    test_mode_switch();
    test_reset_midline();
    test_line_timing();
    test_clkdiv1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
